eqed_inject_ctrl: RTL
=====================

// Module: eqed_inject_ctrl
// PURPOSE
//  Upstream controller for the EQED bit-flip harness; owns the flip-select bus into the design under test.
//  - Once per run, asserts the one-hot per-FF select bus eqed_sel for exactly one cycle at a programmed cycle offset.
//  - Then waits a programmed observation window, captures the output MISR signature and compares it to a golden value.
//  - Replaces the free-running decoder/error_injected logic of the harness with a start/done controlled run.
// PARAMETERS
//  N_FF   8   number of injectable FFs (width of eqed_sel)
//  IDX_W  4   width of ff_idx; values >= N_FF mean "no injection" (control run)
//  CYC_W  10  width of inject_cycle, observe_len and cycle_count
//  SIG_W  6   MISR signature width
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  start         in   1      begin a run; sampled only in IDLE
//  ff_idx        in   IDX_W  target FF index, latched on start
//  inject_cycle  in   CYC_W  K: edges from start edge to injection; 0 treated as 1; latched
//  observe_len   in   CYC_W  L: observation window in cycles; 0 treated as 1; latched
//  golden_sig    in   SIG_W  expected signature, latched on start
//  sig_in        in   SIG_W  output MISR signature from downstream
//  eqed_sel      out  N_FF   one-hot flip select, registered; bit i drives FF i mux
//  injected      out  1      sticky: a flip was actually applied this run
//  busy          out  1      state != IDLE and state != DONE
//  done          out  1      run finished, sig_q/mismatch valid
//  mismatch      out  1      sig_q != golden_q, valid while done
//  sig_q         out  SIG_W  captured signature
//  cycle_count   out  CYC_W  free-running, resets to 1, wraps mod 2^CYC_W
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; eqed_sel=0, injected=0, busy=0, done=0, mismatch=0, sig_q=0, cycle_count=1.
//  Reset mid-run aborts at the same edge; no select pulse after the reset edge.
//  FSM states: IDLE, WAIT, INJECT, OBSERVE, DONE.
//  IDLE:
//   - start=1 at edge E0: latch all inputs, cnt<=1, go WAIT.
//   - start=0: stay IDLE.
//  WAIT: at each edge, if cnt==K go INJECT, else cnt<=cnt+1.
//  INJECT: lasts one cycle; next edge goes OBSERVE with ocnt<=1.
//  eqed_sel and injected:
//   - eqed_sel <= onehot(idx_q) on the edge entering INJECT (E_K), and 0 on every other edge.
//   - Result: eqed_sel is high exactly for the cycle E_K..E_K+1.
//   - idx_q >= N_FF: eqed_sel stays 0 and injected stays 0.
//   - injected <= 1 on the edge eqed_sel becomes nonzero; holds until next start or rst.
//  OBSERVE: at each edge, if ocnt==L then sig_q<=sig_in, mismatch<=(sig_in!=golden_q), go DONE; else ocnt<=ocnt+1.
//   - Capture edge is E_{K+1+L}.
//  DONE:
//   - done=1; outputs held.
//   - start=1 clears done/mismatch/injected and relatches inputs exactly as in IDLE (back-to-back runs allowed).
//  start in WAIT/INJECT/OBSERVE: ignored.
//  K or L = 2^CYC_W-1: the counter reaches the value without wrap; no overflow path.
//  At most one eqed_sel bit is high in any cycle (one-hot or zero).
// STRUCTURE
//  Package eqed_pkg:
//   - state enum (IDLE, WAIT, INJECT, OBSERVE, DONE);
//   - default N_FF/IDX_W/CYC_W/SIG_W localparams;
//   - onehot function.
//  Sub-module eqed_onehot_dec: IDX_W -> N_FF decoder with enable; all-zero for out-of-range index.
//  Top: FSM, cnt/ocnt counters, latched config registers, registered eqed_sel, signature capture/compare.
// TESTING
//  1. start, idx=2, K=3, L=5 -> eqed_sel=8'h04 for exactly one cycle at E3; capture at E9; done=1.
//  2. idx=8, K=1, L=1 -> eqed_sel never nonzero, injected=0; done at E3;
//     golden_sig=sig_in gives mismatch=0.
//  3. K=0, L=0 -> treated as 1/1: pulse at E1, capture at E3.
//  4. golden_sig=6'b110010, sig_in=6'b111010 at capture -> mismatch=1, sig_q=6'b111010.
//  5. rst asserted during WAIT (and separately during INJECT) -> IDLE, eqed_sel=0 next cycle,
//     done=0, cycle_count=1.
//  6. start in DONE (idx=7) -> done drops, new pulse eqed_sel=8'h80;
//     start pulsed during OBSERVE -> ignored.

Source files
------------

// File: rtl/eqed_pkg.sv
// rtl/eqed_pkg.sv - shared widths, state encoding and one-hot helper for the EQED injection controller
package eqed_pkg;

   localparam int N_FF  = 8;
   localparam int IDX_W = 4;
   localparam int CYC_W = 10;
   localparam int SIG_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_INJECT  = 3'd2,
      ST_OBSERVE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Indices at or beyond N_FF decode to all-zero, which is how control runs are expressed.
   function automatic logic [N_FF-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_FF-1:0] res;
      res = '0;
      for (int i = 0; i < N_FF; i++) begin
         res[i] = (idx == IDX_W'(i));
      end
      return res;
   endfunction

endpackage

// File: rtl/eqed_inject_ctrl_if.sv
// rtl/eqed_inject_ctrl_if.sv - run configuration, signature input and flip-select/status bundle
interface eqed_inject_ctrl_if;

   logic                        start;
   logic [eqed_pkg::IDX_W-1:0]  ff_idx;
   logic [eqed_pkg::CYC_W-1:0]  inject_cycle;
   logic [eqed_pkg::CYC_W-1:0]  observe_len;
   logic [eqed_pkg::SIG_W-1:0]  golden_sig;
   logic [eqed_pkg::SIG_W-1:0]  sig_in;
   logic [eqed_pkg::N_FF-1:0]   eqed_sel;
   logic                        injected;
   logic                        busy;
   logic                        done;
   logic                        mismatch;
   logic [eqed_pkg::SIG_W-1:0]  sig_q;
   logic [eqed_pkg::CYC_W-1:0]  cycle_count;

   modport master (
      output start, ff_idx, inject_cycle, observe_len, golden_sig, sig_in,
      input  eqed_sel, injected, busy, done, mismatch, sig_q, cycle_count
   );

   modport slave (
      input  start, ff_idx, inject_cycle, observe_len, golden_sig, sig_in,
      output eqed_sel, injected, busy, done, mismatch, sig_q, cycle_count
   );

endinterface

// File: rtl/eqed_onehot_dec.sv
// rtl/eqed_onehot_dec.sv - index to per-FF select decoder with enable
module eqed_onehot_dec
   import eqed_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [N_FF-1:0]  sel
);

   assign sel = en ? onehot(idx) : '0;

endmodule

// File: rtl/eqed_inject_ctrl.sv
// rtl/eqed_inject_ctrl.sv - start/done controlled single bit-flip run: wait K, pulse select, observe L, compare signature
module eqed_inject_ctrl
   import eqed_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   eqed_inject_ctrl_if.slave  bus
);

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cnt_q, cnt_d;
   logic [CYC_W-1:0]   ocnt_q, ocnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CYC_W-1:0]   k_q, k_d;
   logic [CYC_W-1:0]   l_q, l_d;
   logic [SIG_W-1:0]   golden_q, golden_d;
   logic [N_FF-1:0]    sel_q, sel_d;
   logic               injected_q, injected_d;
   logic               mismatch_q, mismatch_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic [CYC_W-1:0]   cycle_q, cycle_d;
   logic               fire;
   logic [N_FF-1:0]    dec_sel;

   // The select pulse is registered on the edge that leaves WAIT for INJECT.
   assign fire = (state_q == ST_WAIT) && (cnt_q == k_q);

   eqed_onehot_dec u_dec (
      .en  (fire),
      .idx (idx_q),
      .sel (dec_sel)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ocnt_d     = ocnt_q;
      idx_d      = idx_q;
      k_d        = k_q;
      l_d        = l_q;
      golden_d   = golden_q;
      injected_d = injected_q;
      mismatch_d = mismatch_q;
      sig_d      = sig_q;
      sel_d      = dec_sel;
      cycle_d    = cycle_q + CYC_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               idx_d      = bus.ff_idx;
               k_d        = (bus.inject_cycle == '0) ? CYC_W'(1) : bus.inject_cycle;
               l_d        = (bus.observe_len == '0) ? CYC_W'(1) : bus.observe_len;
               golden_d   = bus.golden_sig;
               cnt_d      = CYC_W'(1);
               injected_d = 1'b0;
               mismatch_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == k_q) begin
               state_d = ST_INJECT;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_INJECT: begin
            ocnt_d  = CYC_W'(1);
            state_d = ST_OBSERVE;
         end
         ST_OBSERVE: begin
            if (ocnt_q == l_q) begin
               sig_d      = bus.sig_in;
               mismatch_d = (bus.sig_in != golden_q);
               state_d    = ST_DONE;
            end else begin
               ocnt_d = ocnt_q + CYC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (|dec_sel) begin
         injected_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ocnt_q     <= '0;
         idx_q      <= '0;
         k_q        <= '0;
         l_q        <= '0;
         golden_q   <= '0;
         sel_q      <= '0;
         injected_q <= 1'b0;
         mismatch_q <= 1'b0;
         sig_q      <= '0;
         cycle_q    <= CYC_W'(1);
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ocnt_q     <= ocnt_d;
         idx_q      <= idx_d;
         k_q        <= k_d;
         l_q        <= l_d;
         golden_q   <= golden_d;
         sel_q      <= sel_d;
         injected_q <= injected_d;
         mismatch_q <= mismatch_d;
         sig_q      <= sig_d;
         cycle_q    <= cycle_d;
      end
   end

   assign bus.eqed_sel    = sel_q;
   assign bus.injected    = injected_q;
   assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.mismatch    = mismatch_q;
   assign bus.sig_q       = sig_q;
   assign bus.cycle_count = cycle_q;

endmodule
